// File: rtl/subtractor_nnbit_chunk_serial.sv
// Chunk-serial subtractor: A - B - borrow_in, CHUNK_WIDTH bits per clock, LSB chunk first.
// Valid/ready handshake on both sides; all outputs registered.
module subtractor_nnbit_chunk_serial #(
    parameter int DATA_WIDTH  = 8,
    parameter int CHUNK_WIDTH = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [DATA_WIDTH-1:0] i_num_a,
    input  logic [DATA_WIDTH-1:0] i_num_b,
    input  logic                  i_brw,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [DATA_WIDTH-1:0] o_res,
    output logic                  o_brw,
    output logic                  o_ovf
);
    localparam int NUM_CHUNKS = DATA_WIDTH / CHUNK_WIDTH;
    localparam int CNT_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t                  state;
    logic [DATA_WIDTH-1:0]   a_q;
    logic [DATA_WIDTH-1:0]   b_q;
    logic                    brw_q;
    logic [CNT_W-1:0]        cnt;
    logic [CHUNK_WIDTH-1:0]  a_k;
    logic [CHUNK_WIDTH-1:0]  b_k;
    logic [CHUNK_WIDTH:0]    diff;
    logic                    last;

    // One chunk per cycle; the extra top bit of the widened difference is the borrow out.
    always_comb begin
        a_k  = a_q[cnt*CHUNK_WIDTH +: CHUNK_WIDTH];
        b_k  = b_q[cnt*CHUNK_WIDTH +: CHUNK_WIDTH];
        diff = {1'b0, a_k} - {1'b0, b_k} - {{CHUNK_WIDTH{1'b0}}, brw_q};
        last = (cnt == CNT_W'(NUM_CHUNKS - 1));
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= IDLE;
            o_ready <= 1'b1;
            o_valid <= 1'b0;
            o_res   <= '0;
            o_brw   <= 1'b0;
            o_ovf   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            brw_q   <= 1'b0;
            cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_valid && o_ready) begin
                        a_q     <= i_num_a;
                        b_q     <= i_num_b;
                        brw_q   <= i_brw;
                        cnt     <= '0;
                        o_ready <= 1'b0;
                        state   <= CALC;
                    end
                end
                CALC: begin
                    o_res[cnt*CHUNK_WIDTH +: CHUNK_WIDTH] <= diff[CHUNK_WIDTH-1:0];
                    brw_q <= diff[CHUNK_WIDTH];
                    cnt   <= cnt + CNT_W'(1);
                    if (last) begin
                        // The last chunk's MSB is the result sign bit.
                        o_brw   <= diff[CHUNK_WIDTH];
                        o_ovf   <= (a_q[DATA_WIDTH-1] != b_q[DATA_WIDTH-1]) &&
                                   (diff[CHUNK_WIDTH-1] != a_q[DATA_WIDTH-1]);
                        o_valid <= 1'b1;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    if (i_ready) begin
                        o_valid <= 1'b0;
                        o_ready <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: begin
                    state   <= IDLE;
                    o_ready <= 1'b1;
                    o_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_subtractor_nnbit_chunk_serial.sv
// Directed bench for the chunk-serial subtractor with a result scoreboard.
module tb_subtractor_nnbit_chunk_serial;
    localparam int DW = 8;
    localparam int CW = 4;
    localparam int NC = DW / CW;

    logic          i_clk = 1'b0;
    logic          i_rst, i_valid, i_ready, i_brw;
    logic [DW-1:0] i_num_a, i_num_b;
    logic          o_ready, o_valid, o_brw, o_ovf;
    logic [DW-1:0] o_res;

    typedef struct packed {
        logic [DW-1:0] res;
        logic          brw;
        logic          ovf;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   acc_cyc = 0;
    int   hs_cyc = 0;
    int   npop = 0;
    bit   have_hs = 0;
    bit   b2b = 0;
    logic vld_prev = 1'b0;

    logic [DW-1:0] pa [4] = '{8'hFF, 8'h10, 8'hAA, 8'h01};
    logic [DW-1:0] pb [4] = '{8'hFF, 8'h20, 8'h55, 8'h00};

    subtractor_nnbit_chunk_serial #(.DATA_WIDTH(DW), .CHUNK_WIDTH(CW)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_num_a(i_num_a), .i_num_b(i_num_b), .i_brw(i_brw),
        .o_valid(o_valid), .i_ready(i_ready), .o_res(o_res),
        .o_brw(o_brw), .o_ovf(o_ovf)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Full-width reference: 9-bit difference gives result and borrow directly.
    function automatic exp_t model(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic br);
        exp_t e;
        logic [DW:0] d;
        d = {1'b0, a} - {1'b0, b} - {{DW{1'b0}}, br};
        e.res = d[DW-1:0];
        e.brw = d[DW];
        e.ovf = (a[DW-1] != b[DW-1]) && (d[DW-1] != a[DW-1]);
        return e;
    endfunction

    // Monitor: inputs and outputs are stable at the falling edge.
    always @(negedge i_clk) begin
        exp_t e;
        cyc++;
        if (i_rst === 1'b1) begin
            sb.delete();
        end else begin
            if (o_valid === 1'b1 && vld_prev !== 1'b1)
                chk("latency", cyc - acc_cyc, NC + 1);
            if (o_valid === 1'b1 && i_ready === 1'b1) begin
                chk("sb_nonempty", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("res", o_res, e.res);
                    chk("brw", o_brw, e.brw);
                    chk("ovf", o_ovf, e.ovf);
                end
                npop++;
                if (b2b && have_hs) chk("period", cyc - hs_cyc, NC + 2);
                hs_cyc  = cyc;
                have_hs = b2b;
            end
            if (i_valid === 1'b1 && o_ready === 1'b1) begin
                sb.push_back(model(i_num_a, i_num_b, i_brw));
                acc_cyc = cyc;
            end
        end
        if (!b2b) have_hs = 0;
        vld_prev = o_valid;
    end

    task automatic wait_ready();
        int n = 0;
        while (o_ready !== 1'b1 && n < 30) begin
            @(posedge i_clk); #1;
            n++;
        end
        chk("ready_timeout", o_ready, 1);
    endtask

    task automatic issue(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic br);
        wait_ready();
        i_num_a = a; i_num_b = b; i_brw = br; i_valid = 1'b1;
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        i_num_a = DW'($urandom); i_num_b = DW'($urandom); i_brw = 1'($urandom);
    endtask

    task automatic run(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic br);
        issue(a, b, br);
        wait_ready();
    endtask

    initial begin
        int n;
        i_rst = 1'b1; i_valid = 1'b0; i_ready = 1'b1;
        i_num_a = '0; i_num_b = '0; i_brw = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
        chk("rst_ready", o_ready, 1);
        chk("rst_valid", o_valid, 0);
        chk("rst_res", o_res, 0);
        chk("rst_brw", o_brw, 0);
        chk("rst_ovf", o_ovf, 0);
        i_rst = 1'b0;

        // Simple subtract with explicit timing checks
        issue(8'hF0, 8'h10, 1'b0);
        chk("t0_ready", o_ready, 0);
        @(posedge i_clk); #1;
        chk("t1_ready", o_ready, 0);
        chk("t1_valid", o_valid, 0);
        @(posedge i_clk); #1;
        chk("t2_ready", o_ready, 0);
        chk("t2_valid", o_valid, 1);
        chk("t2_res", o_res, 8'hE0);
        wait_ready();

        // Underflow and signed overflow
        run(8'h00, 8'h01, 1'b0);
        run(8'h05, 8'h05, 1'b1);
        run(8'h80, 8'h01, 1'b0);
        run(8'h7F, 8'hFF, 1'b0);

        // Back-pressure: result held, new operands ignored
        i_ready = 1'b0;
        issue(8'h9C, 8'h3A, 1'b0);
        n = 0;
        while (o_valid !== 1'b1 && n < 30) begin
            @(posedge i_clk); #1;
            n++;
        end
        chk("bp_valid_timeout", o_valid, 1);
        for (int k = 0; k < 4; k++) begin
            i_valid = (k == 1);
            i_num_a = 8'h11; i_num_b = 8'h22; i_brw = 1'b1;
            @(posedge i_clk); #1;
            chk("bp_valid", o_valid, 1);
            chk("bp_ready", o_ready, 0);
            chk("bp_res", o_res, 8'h62);
            chk("bp_brw", o_brw, 0);
            chk("bp_ovf", o_ovf, 1);
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        @(posedge i_clk); #1;
        chk("bp_ready_after", o_ready, 1);
        chk("bp_valid_after", o_valid, 0);
        chk("bp_res_kept", o_res, 8'h62);

        // Reset the cycle after acceptance
        issue(8'h34, 8'h12, 1'b0);
        i_rst = 1'b1;
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        chk("mid_rst_ready", o_ready, 1);
        chk("mid_rst_valid", o_valid, 0);
        chk("mid_rst_res", o_res, 0);
        chk("mid_rst_brw", o_brw, 0);
        chk("mid_rst_ovf", o_ovf, 0);
        run(8'h34, 8'h12, 1'b0);

        // Back-to-back with i_valid and i_ready held high
        b2b = 1;
        i_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            i_num_a = pa[k]; i_num_b = pb[k]; i_brw = 1'b0; i_valid = 1'b1;
            wait_ready();
            @(posedge i_clk); #1;
        end
        i_valid = 1'b0;
        wait_ready();
        b2b = 0;

        repeat (2) @(posedge i_clk);
        #1;
        chk("sb_empty", sb.size(), 0);
        chk("n_results", npop, 11);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
